// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 memory responder: word type, responder FSM states
// and the byte-lane merge used by the display latch.
package slc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        INIT_COPY,
        INIT_LAST,
        READY
    } mem_state_t;

    // Which source feeds Data_from_mem after the most recent read.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_IO
    } rd_src_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

    // be[1] selects bits [15:8], be[0] selects bits [7:0].
    function automatic word_t merge_lanes(word_t old_w, word_t new_w, logic [1:0] be);
        word_t r;
        r = old_w;
        if (be[1]) r[15:8] = new_w[15:8];
        if (be[0]) r[7:0]  = new_w[7:0];
        return r;
    endfunction

endpackage

// File: rtl/slc3_ram_bytewr.sv
// Single-port DEPTH x 16 synchronous RAM with per-byte write enables and an
// enabled, registered read so the last read word holds until the next read.
module slc3_ram_bytewr
    import slc3_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    be_i,
    input  word_t         wdata_i,
    input  logic          rd_en_i,
    output word_t         rdata_o
);

    logic [1:0][7:0] mem_q [DEPTH];
    word_t           rdata_q;

    // NOTE: no reset on the array or its read register, so the tools can map it to block RAM.
    always_ff @(posedge clk_i) begin
        if (be_i[0]) mem_q[addr_i][0] <= wdata_i[7:0];
        if (be_i[1]) mem_q[addr_i][1] <= wdata_i[15:8];
        if (rd_en_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: boot copy from ROM into RAM, then strobe-decoded
// reads and single-commit byte-laned writes to RAM and the I/O word.
module slc3_mem_responder
    import slc3_pkg::*;
#(
    parameter int    RAM_DEPTH  = 1024,
    parameter int    INIT_WORDS = 256,
    parameter word_t IO_ADDR    = IO_ADDR_DEFAULT
) (
    input  logic  Clk,
    input  logic  Reset_n,
    input  logic  Mem_CE,
    input  logic  Mem_OE,
    input  logic  Mem_WE,
    input  logic  Mem_UB,
    input  logic  Mem_LB,
    input  word_t Addr,
    input  word_t Data_to_mem,
    output word_t Data_from_mem,
    input  word_t Switches,
    output word_t Hex_out,
    output word_t Rom_addr,
    input  word_t Rom_data,
    output logic  Init_done
);

    localparam int AW = $clog2(RAM_DEPTH);

    mem_state_t    state_q, state_d;
    word_t         rom_addr_q, rom_addr_d;
    logic          pipe_vld_q, pipe_vld_d;
    logic [AW-1:0] pipe_addr_q, pipe_addr_d;
    word_t         pipe_data_q, pipe_data_d;
    logic          we_q;
    word_t         sw_meta_q, sw_sync_q;
    word_t         hex_q, hex_d;
    rd_src_t       src_q, src_d;
    word_t         io_rd_q, io_rd_d;
    logic          init_done_q, init_done_d;

    logic          rd_req, wr_req, is_io, is_ram;
    logic [1:0]    lanes;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_be;
    word_t         ram_wdata;
    logic          ram_rd;
    word_t         ram_rdata;

    // A write commits only on the first cycle WE is seen low (we_q still high).
    assign is_io  = (Addr == IO_ADDR);
    assign is_ram = !is_io && (32'(Addr) < RAM_DEPTH);
    assign lanes  = {~Mem_UB, ~Mem_LB};
    assign rd_req = (state_q == READY) && !Mem_CE && !Mem_OE && Mem_WE;
    assign wr_req = (state_q == READY) && !Mem_CE && !Mem_WE && we_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= INIT_COPY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT_COPY: if (rom_addr_q == 16'(INIT_WORDS)) state_d = INIT_LAST;
            INIT_LAST: state_d = READY;
            READY:     state_d = READY;
            default:   state_d = INIT_COPY;
        endcase
    end

    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        rom_addr_d  = rom_addr_q;
        pipe_vld_d  = 1'b0;
        pipe_addr_d = AW'(rom_addr_q - 16'd1);
        pipe_data_d = Rom_data;
        hex_d       = hex_q;
        src_d       = src_q;
        io_rd_d     = io_rd_q;
        init_done_d = (state_d == READY);

        if (state_q == INIT_COPY) begin
            rom_addr_d = rom_addr_q + 16'd1;
            pipe_vld_d = (rom_addr_q != 16'd0);
        end

        if (wr_req && is_io) hex_d = merge_lanes(hex_q, Data_to_mem, lanes);

        if (rd_req) begin
            src_d = is_io ? SRC_IO : (is_ram ? SRC_RAM : SRC_ZERO);
            if (is_io) io_rd_d = sw_sync_q;
        end

        // The boot pipeline owns the RAM port until READY; no CPU access can overlap it.
        ram_addr  = Addr[AW-1:0];
        ram_be    = (wr_req && is_ram) ? lanes : 2'b00;
        ram_wdata = Data_to_mem;
        ram_rd    = rd_req && is_ram;
        if (pipe_vld_q) begin
            ram_addr  = pipe_addr_q;
            ram_be    = 2'b11;
            ram_wdata = pipe_data_q;
            ram_rd    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_addr_q <= '0;
            pipe_data_q <= '0;
            we_q        <= 1'b1;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            hex_q       <= '0;
            src_q       <= SRC_ZERO;
            io_rd_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            pipe_data_q <= pipe_data_d;
            we_q        <= Mem_WE;
            sw_meta_q   <= Switches;
            sw_sync_q   <= sw_meta_q;
            hex_q       <= hex_d;
            src_q       <= src_d;
            io_rd_q     <= io_rd_d;
            init_done_q <= init_done_d;
        end
    end

    slc3_ram_bytewr #(
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (Clk),
        .addr_i  (ram_addr),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rd_en_i (ram_rd),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        unique case (src_q)
            SRC_RAM: Data_from_mem = ram_rdata;
            SRC_IO:  Data_from_mem = io_rd_q;
            default: Data_from_mem = '0;
        endcase
    end

    assign Hex_out   = hex_q;
    assign Rom_addr  = rom_addr_q;
    assign Init_done = init_done_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: boot copy timing, byte-laned
// writes, I/O mapping, unmapped addresses and reset during the boot copy.
module tb_slc3_mem_responder;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
    logic [15:0] Addr, Data_to_mem, Data_from_mem;
    logic [15:0] Switches, Hex_out, Rom_addr, Rom_data;
    logic        Init_done;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    // Synchronous boot ROM: data for an address appears one cycle later.
    always @(posedge Clk) Rom_data <= Rom_addr ^ 16'hA5A5;

    slc3_mem_responder #(
        .RAM_DEPTH  (1024),
        .INIT_WORDS (4),
        .IO_ADDR    (16'hFFFF)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Mem_CE        (Mem_CE),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .Mem_UB        (Mem_UB),
        .Mem_LB        (Mem_LB),
        .Addr          (Addr),
        .Data_to_mem   (Data_to_mem),
        .Data_from_mem (Data_from_mem),
        .Switches      (Switches),
        .Hex_out       (Hex_out),
        .Rom_addr      (Rom_addr),
        .Rom_data      (Rom_data),
        .Init_done     (Init_done)
    );

    task automatic drive_idle();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(negedge Clk);
    endtask

    // Holds WE low for 'cycles' edges; data switches to d2 after the first cycle.
    task automatic issue_write(input logic [15:0] a, input logic [15:0] d, input logic ub,
                               input logic lb, input int cycles, input logic [15:0] d2);
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0;
        Mem_UB = ub; Mem_LB = lb; Addr = a; Data_to_mem = d;
        @(negedge Clk);
        for (int i = 1; i < cycles; i++) begin
            Data_to_mem = d2;
            @(negedge Clk);
        end
        drive_idle();
    endtask

    task automatic issue_read(input logic [15:0] a, input logic [15:0] exp, input string name);
        exp_t it;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Addr = a;
        it.name = name; it.exp = exp;
        sb_q.push_back(it);
        @(negedge Clk);
        drive_idle();
    endtask

    task automatic test_reset();
        logic [15:0] boot_exp [4];
        boot_exp[0] = 16'hA5A5; boot_exp[1] = 16'hA5A4;
        boot_exp[2] = 16'hA5A7; boot_exp[3] = 16'hA5A6;
        Reset_n = 1'b0; drive_idle();
        Addr = '0; Data_to_mem = '0; Switches = '0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (Data_from_mem !== 16'h0 || Hex_out !== 16'h0 || Rom_addr !== 16'h0 || Init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: dfm=%h hex=%h rom=%h done=%b required 0/0/0/0",
                     Data_from_mem, Hex_out, Rom_addr, Init_done);
        end
        Reset_n = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (Init_done !== (cyc == 6)) begin
                n_fail++;
                $display("FAIL boot_done_timing: cycle %0d Init_done=%b required %b", cyc, Init_done, cyc == 6);
            end
        end
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            issue_read(16'(i), boot_exp[i], $sformatf("boot_word_%0d", i));
            e = sb_q.pop_front();
            n_checks++;
            if (Data_from_mem !== e.exp) begin
                n_fail++;
                $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
            end
        end
    endtask

    task automatic test_single_commit();
        issue_write(16'h0010, 16'h1234, 1'b0, 1'b0, 2, 16'hFFFF);
        idle(1);
        issue_read(16'h0010, 16'h1234, "single_commit");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
    endtask

    task automatic test_byte_lanes();
        issue_write(16'h0010, 16'hBEEF, 1'b1, 1'b0, 1, 16'hBEEF);
        issue_read(16'h0010, 16'h12EF, "lb_only_write");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
        issue_write(16'h0010, 16'h0000, 1'b0, 1'b1, 1, 16'h0000);
        issue_read(16'h0010, 16'h00EF, "ub_only_write");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
    endtask

    task automatic test_io();
        Switches = 16'h3000;
        idle(2);
        issue_read(16'hFFFF, 16'h3000, "io_switch_read");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
        issue_write(16'hFFFF, 16'h00C3, 1'b0, 1'b0, 1, 16'h00C3);
        n_checks++;
        if (Hex_out !== 16'h00C3) begin
            n_fail++;
            $display("FAIL hex_write: Hex_out=%h required %h", Hex_out, 16'h00C3);
        end
        idle(1);
        issue_write(16'hFFFF, 16'h1155, 1'b1, 1'b0, 1, 16'h1155);
        n_checks++;
        if (Hex_out !== 16'h0055) begin
            n_fail++;
            $display("FAIL hex_lb_write: Hex_out=%h required %h", Hex_out, 16'h0055);
        end
    endtask

    task automatic test_write_wins_and_unmapped();
        issue_read(16'h0010, 16'h00EF, "pre_dual_read");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Addr = 16'h0020; Data_to_mem = 16'h5555;
        @(negedge Clk);
        drive_idle();
        n_checks++;
        if (Data_from_mem !== 16'h00EF) begin
            n_fail++;
            $display("FAIL dual_strobe_hold: Data_from_mem=%h required %h", Data_from_mem, 16'h00EF);
        end
        issue_read(16'h0020, 16'h5555, "dual_strobe_write");
        issue_read(16'h8000, 16'h0000, "unmapped_read_8000");
        e = sb_q.pop_front();
        n_checks++;
        if (e.name != "dual_strobe_write") begin
            n_fail++;
            $display("FAIL scoreboard_order: got entry %s required dual_strobe_write", e.name);
        end
        issue_write(16'h0400, 16'h7777, 1'b0, 1'b0, 1, 16'h7777);
        issue_read(16'h0000, 16'hA5A5, "no_wrap_at_depth");
        e = sb_q.pop_front();
        n_checks++;
        if (e.name != "unmapped_read_8000") begin
            n_fail++;
            $display("FAIL scoreboard_order: got entry %s required unmapped_read_8000", e.name);
        end
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
        issue_read(16'h0400, 16'h0000, "unmapped_read_0400");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
    endtask

    task automatic test_back_to_back();
        issue_write(16'h0030, 16'hCAFE, 1'b0, 1'b0, 1, 16'hCAFE);
        issue_read(16'h0030, 16'hCAFE, "write_first_read");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
        idle(2);
        n_checks++;
        if (Data_from_mem !== 16'hCAFE) begin
            n_fail++;
            $display("FAIL read_data_hold: Data_from_mem=%h required %h", Data_from_mem, 16'hCAFE);
        end
        issue_write(16'h0031, 16'h0101, 1'b0, 1'b0, 1, 16'h0101);
        idle(1);
        Mem_CE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Addr = 16'h0031; Data_to_mem = 16'h9999;
        @(negedge Clk);
        Mem_CE = 1'b0;
        @(negedge Clk);
        drive_idle();
        issue_read(16'h0031, 16'h0101, "ce_gated_we_no_commit");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
    endtask

    task automatic test_reset_mid_copy();
        issue_write(16'h0040, 16'h1111, 1'b0, 1'b0, 1, 16'h1111);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        n_checks++;
        if (Rom_addr !== 16'h0002) begin
            n_fail++;
            $display("FAIL copy_progress: Rom_addr=%h required %h", Rom_addr, 16'h0002);
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (Rom_addr !== 16'h0000 || Init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_copy_reset: Rom_addr=%h Init_done=%b required 0000/0", Rom_addr, Init_done);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            drive_idle();
            Addr = 16'h0040;
            if (cyc == 1) begin
                Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0; Data_to_mem = 16'h2222;
            end else if (cyc == 2) begin
                Mem_CE = 1'b0; Mem_OE = 1'b0;
            end
            @(posedge Clk); #1;
            n_checks++;
            if (Init_done !== (cyc == 6) || Data_from_mem !== 16'h0) begin
                n_fail++;
                $display("FAIL recopy_cycle_%0d: Init_done=%b dfm=%h required %b/0000",
                         cyc, Init_done, Data_from_mem, cyc == 6);
            end
            if (cyc <= 4) begin
                n_checks++;
                if (Rom_addr !== 16'(cyc)) begin
                    n_fail++;
                    $display("FAIL recopy_rom_addr_%0d: Rom_addr=%h required %h", cyc, Rom_addr, 16'(cyc));
                end
            end
            @(negedge Clk);
        end
        drive_idle();
        issue_read(16'h0040, 16'h1111, "pre_ready_write_ignored");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
        issue_read(16'h0002, 16'hA5A7, "recopy_word_2");
        e = sb_q.pop_front();
        n_checks++;
        if (Data_from_mem !== e.exp) begin
            n_fail++;
            $display("FAIL %s: Data_from_mem=%h required %h", e.name, Data_from_mem, e.exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_commit();
        test_byte_lanes();
        test_io();
        test_write_wins_and_unmapped();
        test_back_to_back();
        test_reset_mid_copy();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
